// File: rtl/exec_pkg.sv
// Shared types for the execute stage: FSM states, ALU opcodes, and the immediate sign-extension helper.
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } exec_state_e;

    localparam logic ALU_ADD  = 1'b0;
    localparam logic ALU_BINS = 1'b1;

    // Sign-extend the low w bits of v to 64 bits; callers truncate to their own width.
    function automatic logic [63:0] sext64(input logic [63:0] v, input int unsigned w);
        logic [63:0] sh;
        sh = v << (64 - w);
        return $signed(sh) >>> (64 - w);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational execute ALU: ADD (modulo width) or BYTE_INSERT of b[7:0] into byte lane of a.
// Zero latency, no backpressure.
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic             i_alu_op,
    input  logic [DATAW-1:0] i_a,
    input  logic [DATAW-1:0] i_b,
    input  logic [1:0]       i_shift_dist,
    output logic [DATAW-1:0] o_result
);

    always_comb begin
        o_result = i_a + i_b;
        if (i_alu_op == ALU_BINS) begin
            o_result = i_a;
            o_result[{i_shift_dist, 3'b000} +: 8] = i_b[7:0];
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch resolve, FFT req/ack handshake, X/M register (1-cycle latency).
// Stalls upstream on mem_stall_in or while an FFT write is in flight. Optional macro: EXEC_FFT_TIMEOUT_EN.
module execute_stage
    import exec_pkg::*;
#(
    parameter int DATAW       = 32,
    parameter int PCW         = 32,
    parameter int IMMW        = 11,
    parameter int REGW        = 3,
    parameter int FFT_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_op_in,
    input  logic             use_imm_in,
    input  logic             reg_wr_en_in,
    input  logic             mem_wr_en_in,
    input  logic             branch_in,
    input  logic             fft_wr_en_in,
    input  logic [1:0]       shift_dist_in,
    input  logic [REGW-1:0]  wr_reg_in,
    input  logic [IMMW-1:0]  imm_in,
    input  logic [PCW-1:0]   PC_in,
    input  logic [DATAW-1:0] a_in,
    input  logic [DATAW-1:0] b_in,
    input  logic             mem_stall_in,
    input  logic             fft_ack_in,
    output logic             stall_out,
    output logic             flush_out,
    output logic [PCW-1:0]   redirect_pc_out,
    output logic             fft_req_out,
    output logic [DATAW-1:0] fft_addr_out,
    output logic [DATAW-1:0] fft_data_out,
    output logic             fft_err_out,
    output logic [DATAW-1:0] result_out,
    output logic [DATAW-1:0] store_data_out,
    output logic             reg_wr_en_out,
    output logic             mem_wr_en_out,
    output logic [REGW-1:0]  wr_reg_out
);

    exec_state_e      r_state;
    logic [DATAW-1:0] w_imm_d;
    logic [PCW-1:0]   w_imm_pc;
    logic [DATAW-1:0] w_b;
    logic [DATAW-1:0] w_alu;
    logic             w_fft_op;
    logic             w_fft_start;
    logic             w_stall;
    logic             w_taken;

    assign w_imm_d  = DATAW'(sext64(64'(imm_in), IMMW));
    assign w_imm_pc = PCW'(sext64(64'(imm_in), IMMW));
    assign w_b      = use_imm_in ? w_imm_d : b_in;

    exec_alu #(.DATAW(DATAW)) u_alu (
        .i_alu_op     (alu_op_in),
        .i_a          (a_in),
        .i_b          (w_b),
        .i_shift_dist (shift_dist_in),
        .o_result     (w_alu)
    );

    // A branch wins over an FFT write decoded in the same instruction.
    assign w_fft_op    = fft_wr_en_in && !branch_in;
    assign w_fft_start = (r_state == IDLE) && w_fft_op;
    assign w_stall     = mem_stall_in || w_fft_start || (r_state == WAIT);
    assign w_taken     = branch_in && (a_in == '0) && !w_stall;

    assign stall_out       = rst_n && w_stall;
    assign flush_out       = rst_n && w_taken;
    assign redirect_pc_out = (rst_n && w_taken) ? (PC_in + w_imm_pc) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_out     <= '0;
            store_data_out <= '0;
            reg_wr_en_out  <= 1'b0;
            mem_wr_en_out  <= 1'b0;
            wr_reg_out     <= '0;
        end else if (!w_stall) begin
            result_out     <= w_fft_op ? '0 : w_alu;
            store_data_out <= b_in;
            reg_wr_en_out  <= reg_wr_en_in;
            mem_wr_en_out  <= mem_wr_en_in;
            wr_reg_out     <= wr_reg_in;
        end
    end

`ifdef EXEC_FFT_TIMEOUT_EN
    localparam int CNTW = $clog2(FFT_TIMEOUT + 1);
    logic [CNTW-1:0] r_cnt;
    logic            r_err;
    assign fft_err_out = r_err;
`else
    assign fft_err_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            fft_req_out  <= 1'b0;
            fft_addr_out <= '0;
            fft_data_out <= '0;
`ifdef EXEC_FFT_TIMEOUT_EN
            r_cnt        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fft_start) begin
                        r_state      <= WAIT;
                        fft_req_out  <= 1'b1;
                        fft_addr_out <= w_b;
                        fft_data_out <= a_in;
`ifdef EXEC_FFT_TIMEOUT_EN
                        r_cnt        <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (fft_ack_in) begin
                        r_state     <= DONE;
                        fft_req_out <= 1'b0;
`ifdef EXEC_FFT_TIMEOUT_EN
                    end else if (r_cnt == CNTW'(FFT_TIMEOUT - 1)) begin
                        r_state     <= DONE;
                        fft_req_out <= 1'b0;
                        r_err       <= 1'b1;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    if (!mem_stall_in) r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    fft_req_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU, branch, X/M hold, FFT handshake, timeout/no-timeout, reset in WAIT.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_op_in, use_imm_in, reg_wr_en_in, mem_wr_en_in, branch_in, fft_wr_en_in;
    logic [1:0]  shift_dist_in;
    logic [2:0]  wr_reg_in;
    logic [10:0] imm_in;
    logic [31:0] PC_in, a_in, b_in;
    logic        mem_stall_in, fft_ack_in;
    logic        stall_out, flush_out, fft_req_out, fft_err_out;
    logic [31:0] redirect_pc_out, fft_addr_out, fft_data_out, result_out, store_data_out;
    logic        reg_wr_en_out, mem_wr_en_out;
    logic [2:0]  wr_reg_out;

    int n_chk = 0;
    int n_err = 0;
    int n_stall;
    int n_req;
    int n_rise;
    logic prev_req;

    always #5 clk = ~clk;

    execute_stage #(.FFT_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_op_in(alu_op_in), .use_imm_in(use_imm_in),
        .reg_wr_en_in(reg_wr_en_in), .mem_wr_en_in(mem_wr_en_in),
        .branch_in(branch_in), .fft_wr_en_in(fft_wr_en_in),
        .shift_dist_in(shift_dist_in), .wr_reg_in(wr_reg_in), .imm_in(imm_in),
        .PC_in(PC_in), .a_in(a_in), .b_in(b_in),
        .mem_stall_in(mem_stall_in), .fft_ack_in(fft_ack_in),
        .stall_out(stall_out), .flush_out(flush_out), .redirect_pc_out(redirect_pc_out),
        .fft_req_out(fft_req_out), .fft_addr_out(fft_addr_out), .fft_data_out(fft_data_out),
        .fft_err_out(fft_err_out), .result_out(result_out), .store_data_out(store_data_out),
        .reg_wr_en_out(reg_wr_en_out), .mem_wr_en_out(mem_wr_en_out), .wr_reg_out(wr_reg_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        alu_op_in = 0; use_imm_in = 0; reg_wr_en_in = 0; mem_wr_en_in = 0;
        branch_in = 0; fft_wr_en_in = 0; shift_dist_in = 0; wr_reg_in = 0;
        imm_in = 0; PC_in = 0; a_in = 0; b_in = 0; mem_stall_in = 0; fft_ack_in = 0;
    endtask

    initial begin
        clr();
        rst_n = 0;
        fft_wr_en_in = 1; mem_stall_in = 1; branch_in = 1; PC_in = 32'h100;
        #3;
        check("rst_stall", stall_out, 0);
        check("rst_flush", flush_out, 0);
        check("rst_redirect", redirect_pc_out, 0);
        check("rst_req", fft_req_out, 0);
        check("rst_result", result_out, 0);
        check("rst_err", fft_err_out, 0);
        clr();
        @(negedge clk);
        rst_n = 1;
        nxt();
        check("idle_stall", stall_out, 0);

        // ALU
        use_imm_in = 1; imm_in = 11'h7FF; a_in = 5; reg_wr_en_in = 1; wr_reg_in = 3;
        nxt();
        check("add_imm_res", result_out, 32'd4);
        check("add_imm_rwe", reg_wr_en_out, 1);
        check("add_imm_wreg", wr_reg_out, 3);
        use_imm_in = 0; a_in = 32'hFFFF_FFFF; b_in = 2; reg_wr_en_in = 0; mem_wr_en_in = 1; wr_reg_in = 0;
        nxt();
        check("add_wrap_res", result_out, 32'd1);
        check("add_store", store_data_out, 32'd2);
        check("add_mwe", mem_wr_en_out, 1);
        check("add_rwe0", reg_wr_en_out, 0);
        mem_wr_en_in = 0; reg_wr_en_in = 1; alu_op_in = 1;
        a_in = 32'h1122_3344; b_in = 32'hAB; shift_dist_in = 2;
        nxt();
        check("bins_sd2", result_out, 32'h11AB_3344);
        b_in = 32'h1CD; shift_dist_in = 0;
        nxt();
        check("bins_sd0", result_out, 32'h1122_33CD);
        shift_dist_in = 3;
        nxt();
        check("bins_sd3", result_out, 32'hCD22_3344);

        // Downstream stall holds X/M
        alu_op_in = 0; a_in = 1; b_in = 1; mem_stall_in = 1;
        #1 check("mstall_out", stall_out, 1);
        nxt();
        check("mstall_hold1", result_out, 32'hCD22_3344);
        nxt();
        check("mstall_hold2", result_out, 32'hCD22_3344);
        mem_stall_in = 0;
        #1 check("mstall_rel", stall_out, 0);
        nxt();
        check("mstall_load", result_out, 32'd2);

        // Branch
        reg_wr_en_in = 0; branch_in = 1; a_in = 0; b_in = 7; PC_in = 32'h100; imm_in = 11'h7FC;
        #1 check("br_flush", flush_out, 1);
        check("br_target", redirect_pc_out, 32'hFC);
        check("br_nostall", stall_out, 0);
        a_in = 1;
        #1 check("br_nt_flush", flush_out, 0);
        a_in = 0; mem_stall_in = 1;
        #1 check("br_stalled", flush_out, 0);
        mem_stall_in = 0; fft_wr_en_in = 1;
        #1 check("br_fft_flush", flush_out, 1);
        check("br_fft_stall", stall_out, 0);
        nxt();
        check("br_fft_noreq", fft_req_out, 0);
        check("br_fft_res", result_out, 32'd7);

        // FFT handshake, ack 3 cycles after req
        branch_in = 0; fft_wr_en_in = 1; a_in = 32'hDEAD_BEEF; b_in = 32'h40;
        reg_wr_en_in = 1; wr_reg_in = 5;
        n_stall = 0; n_req = 0; n_rise = 0; prev_req = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) fft_ack_in = 1;
            if (c == 5) fft_ack_in = 0;
            if (c == 6) begin
                fft_wr_en_in = 0; reg_wr_en_in = 0; wr_reg_in = 0; a_in = 0; b_in = 0;
            end
            #1;
            n_stall += int'(stall_out);
            n_req   += int'(fft_req_out);
            if (fft_req_out && !prev_req) n_rise++;
            prev_req = fft_req_out;
            if (c == 1) begin
                check("fft_addr", fft_addr_out, 32'h40);
                check("fft_data", fft_data_out, 32'hDEAD_BEEF);
            end
            if (c == 5) check("fft_done_hold", result_out, 32'd7);
            if (c == 6) begin
                check("fft_retire_res", result_out, 0);
                check("fft_retire_rwe", reg_wr_en_out, 1);
                check("fft_retire_wreg", wr_reg_out, 5);
            end
            if (c == 7) check("fft_bubble_rwe", reg_wr_en_out, 0);
            nxt();
        end
        check("fft_stall_cycles", n_stall, 5);
        check("fft_req_cycles", n_req, 4);
        check("fft_req_pulses", n_rise, 1);
        check("fft_err_clean", fft_err_out, 0);

        // Ack outside WAIT is ignored
        fft_ack_in = 1;
        nxt();
        check("ack_idle_req", fft_req_out, 0);
        check("ack_idle_stall", stall_out, 0);
        fft_ack_in = 0;

        // Downstream stall while in WAIT
        a_in = 3; b_in = 4; reg_wr_en_in = 1;
        nxt();
        check("pre_ms_res", result_out, 32'd7);
        fft_wr_en_in = 1; a_in = 1; b_in = 2;
        nxt();
        mem_stall_in = 1; fft_ack_in = 1;
        #1 check("msw_req", fft_req_out, 1);
        nxt();
        fft_ack_in = 0;
        check("msw_req_drop", fft_req_out, 0);
        check("msw_stall", stall_out, 1);
        nxt();
        check("msw_hold", result_out, 32'd7);
        mem_stall_in = 0;
        #1 check("msw_rel", stall_out, 0);
        nxt();
        fft_wr_en_in = 0;
        check("msw_retire", result_out, 0);
        #1 check("msw_idle", stall_out, 0);

        // No ack: timeout with the macro, indefinite wait without it
        fft_wr_en_in = 1; a_in = 0;
        nxt();
        nxt();
        nxt();
        nxt();
        check("to_req_w4", fft_req_out, 1);
        nxt();
`ifdef EXEC_FFT_TIMEOUT_EN
        check("to_req_drop", fft_req_out, 0);
        check("to_err", fft_err_out, 1);
        check("to_done_stall", stall_out, 0);
        nxt();
        fft_wr_en_in = 0;
        nxt();
        nxt();
        check("to_err_sticky", fft_err_out, 1);
        check("to_req_idle", fft_req_out, 0);
`else
        check("nto_req", fft_req_out, 1);
        check("nto_err", fft_err_out, 0);
        check("nto_stall", stall_out, 1);
        repeat (5) nxt();
        check("nto_req_late", fft_req_out, 1);
        fft_ack_in = 1;
        nxt();
        fft_ack_in = 0;
        check("nto_req_drop", fft_req_out, 0);
        nxt();
        fft_wr_en_in = 0;
        check("nto_err_end", fft_err_out, 0);
`endif

        // Reset while in WAIT
        fft_wr_en_in = 1; a_in = 9; b_in = 8; reg_wr_en_in = 1;
        nxt();
        check("rw_req", fft_req_out, 1);
        #2 rst_n = 0;
        #1;
        check("rw_req_async", fft_req_out, 0);
        check("rw_stall", stall_out, 0);
        check("rw_res", result_out, 0);
        check("rw_err", fft_err_out, 0);
        check("rw_addr", fft_addr_out, 0);
        @(negedge clk);
        rst_n = 1;
        nxt();
        check("rw_req2", fft_req_out, 1);
        check("rw_addr2", fft_addr_out, 32'h8);
        fft_ack_in = 1;
        nxt();
        fft_ack_in = 0;
        check("rw_req2_drop", fft_req_out, 0);
        nxt();
        fft_wr_en_in = 0;
        check("rw_retire_res", result_out, 0);
        check("rw_retire_rwe", reg_wr_en_out, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
